// File: rtl/tis_pkg.sv
// tis_pkg: shared word type and arbiter state encoding for the TIS node port blocks.
package tis_pkg;
    localparam int WORD_W = 11;
    typedef logic signed [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_t;
endpackage

// File: rtl/port_arbiter_if.sv
// port_arbiter_if: requester-side and node-side handshake bundle of the port arbiter.
interface port_arbiter_if #(parameter int N = 4, parameter int W = 11);
    logic [N-1:0]           req_write;
    logic signed [W-1:0]    req_data [0:N-1];
    logic [N-1:0]           req_wready;
    logic                   wready;
    logic                   write;
    logic signed [W-1:0]    out;
    logic [$clog2(N)-1:0]   grant_id;
    logic                   busy;
    modport master (input req_write, req_data, wready, output req_wready, write, out, grant_id, busy);
    modport slave (output req_write, req_data, wready, input req_wready, write, out, grant_id, busy);
endinterface

// File: rtl/port_arbiter_rr_pick.sv
// rr_pick: round-robin search for the first asserted request after rr_ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          found,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] c;
    // Scan farthest to nearest so the nearest hit after rr_ptr wins.
    always_comb begin
        found = 1'b0;
        idx = '0;
        c = '0;
        for (int k = N; k >= 1; k--) begin
            c = IW'((int'(rr_ptr) + k) % N);
            if (req[c]) begin
                found = 1'b1;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: round-robin sharing of one node input port among N producers, registered write/out.
// Define PORT_ARB_COUNT_EN to add xfer_count and abort_count outputs.
module port_arbiter
    import tis_pkg::*;
#(
    parameter int N = 4,
    parameter int W = WORD_W
) (
    input logic clk,
    input logic rst,
    port_arbiter_if.master bus
`ifdef PORT_ARB_COUNT_EN
    ,
    output logic [15:0] xfer_count,
    output logic [7:0]  abort_count
`endif
);
    localparam int IW = $clog2(N);

    arb_state_t          state_q, state_d;
    logic                write_q, write_d;
    logic signed [W-1:0] out_q, out_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic                found;
    logic [IW-1:0]       win;
    logic                done;
    logic                abort;

    rr_pick #(.N(N)) u_pick (
        .req    (bus.req_write),
        .rr_ptr (rr_q),
        .found  (found),
        .idx    (win)
    );

    // A completed transfer takes precedence over a simultaneous requester drop.
    assign done  = (state_q == BUSY) && bus.wready;
    assign abort = (state_q == BUSY) && !bus.wready && !bus.req_write[grant_q];

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        out_d   = out_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        if (state_q == IDLE && found) begin
            state_d = BUSY;
            write_d = 1'b1;
            grant_d = win;
            out_d   = bus.req_data[win];
        end
        if (done) begin
            state_d = GAP;
            write_d = 1'b0;
            rr_d    = grant_q;
        end
        if (abort) begin
            state_d = IDLE;
            write_d = 1'b0;
        end
        if (state_q == GAP) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            out_q   <= '0;
            grant_q <= '0;
            rr_q    <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            out_q   <= out_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.req_wready = done ? (N'(1) << grant_q) : '0;
    assign bus.write      = write_q;
    assign bus.out        = out_q;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = (state_q == BUSY);

`ifdef PORT_ARB_COUNT_EN
    logic [15:0] xfer_q, xfer_d;
    logic [7:0]  abort_q, abort_d;

    always_comb begin
        xfer_d  = xfer_q + 16'(done);
        abort_d = abort_q + 8'(abort && abort_q != 8'hFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_q  <= '0;
            abort_q <= '0;
        end else begin
            xfer_q  <= xfer_d;
            abort_q <= abort_d;
        end
    end

    assign xfer_count  = xfer_q;
    assign abort_count = abort_q;
`endif
endmodule

// File: tb/tb_port_arbiter.sv
// tb_port_arbiter: directed stimulus with a scoreboard of expected accept pulses checked by a monitor.
module tb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int         idx;
        logic [10:0] data;
    } exp_t;
    exp_t exp_q[$];

    port_arbiter_if #(.N(4), .W(11)) bus();

`ifdef PORT_ARB_COUNT_EN
    logic [15:0] xfer_count;
    logic [7:0]  abort_count;
`endif

    port_arbiter #(.N(4), .W(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef PORT_ARB_COUNT_EN
        ,
        .xfer_count  (xfer_count),
        .abort_count (abort_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [10:0] data);
        exp_t e;
        e.idx = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_pulse(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (bus.req_wready == '0 && cycles < 20);
        if (bus.req_wready == '0) chk("pulse_timeout", 32'(cycles), 32'd0);
    endtask

    // Monitor: every accept pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (bus.req_wready != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {28'd0, bus.req_wready}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_onehot", {28'd0, bus.req_wready}, 32'd1 << e.idx);
                chk("pulse_out", {21'd0, bus.out}, {21'd0, e.data});
                chk("pulse_write", {31'd0, bus.write}, 32'd1);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        int order [5] = '{0, 1, 2, 3, 0};
        bus.req_write = '0;
        bus.wready = 1'b0;
        for (int i = 0; i < 4; i++) bus.req_data[i] = '0;
        #1;
        do_reset();
        chk("rst_write", {31'd0, bus.write}, 32'd0);
        chk("rst_out", {21'd0, bus.out}, 32'd0);
        chk("rst_grant", {30'd0, bus.grant_id}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);

        // All four requesting, wready tied high.
        for (int i = 0; i < 4; i++) bus.req_data[i] = 11'(10 * (i + 1));
        for (int k = 0; k < 5; k++) push(order[k], 11'(10 * (order[k] + 1)));
        bus.req_write = 4'b1111;
        bus.wready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_pulse(cyc);
            chk("rr_grant", {30'd0, bus.grant_id}, 32'(order[k]));
            chk("rr_period", 32'(cyc), k == 0 ? 32'd1 : 32'd3);
        end
        bus.req_write = '0;
        tick();
        bus.wready = 1'b0;
        tick();

        // Backpressure on requester 1; data change while granted is ignored.
        bus.req_data[1] = 11'sd100;
        bus.req_write = 4'b0010;
        tick();
        chk("bp_grant", {30'd0, bus.grant_id}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) bus.req_data[1] = 11'sd7;
            tick();
            chk("bp_out", {21'd0, bus.out}, 32'd100);
            chk("bp_write", {31'd0, bus.write}, 32'd1);
        end
        push(1, 11'd100);
        bus.wready = 1'b1;
        tick();
        bus.req_write = '0;
        bus.wready = 1'b0;
        chk("bp_write_drop", {31'd0, bus.write}, 32'd0);
        tick();
        tick();

        // Single request on port 2 with a negative word.
        bus.req_data[2] = -11'sd5;
        bus.req_write = 4'b0100;
        tick();
        chk("single_write", {31'd0, bus.write}, 32'd1);
        chk("single_out", {21'd0, bus.out}, 32'h7FB);
        chk("single_grant", {30'd0, bus.grant_id}, 32'd2);
        push(2, 11'h7FB);
        bus.wready = 1'b1;
        tick();
        bus.req_write = '0;
        bus.wready = 1'b0;
        chk("single_write_drop", {31'd0, bus.write}, 32'd0);
        chk("single_busy_drop", {31'd0, bus.busy}, 32'd0);
        tick();
        tick();

        // Abort right after reset leaves rr_ptr at N-1.
        do_reset();
        bus.req_data[3] = 11'sd33;
        bus.req_write = 4'b1000;
        tick();
        chk("abort_grant", {30'd0, bus.grant_id}, 32'd3);
        bus.req_write = '0;
        tick();
        chk("abort_write", {31'd0, bus.write}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        bus.req_data[0] = 11'sd5;
        bus.req_write = 4'b1001;
        tick();
        chk("abort_next_grant", {30'd0, bus.grant_id}, 32'd0);
        push(0, 11'd5);
        bus.wready = 1'b1;
        tick();
        bus.req_write = '0;
        bus.wready = 1'b0;
        tick();
        tick();

        // Asynchronous reset while BUSY.
        bus.req_data[2] = 11'sd55;
        bus.req_write = 4'b0100;
        tick();
        chk("areset_pre_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst = 1'b1;
        bus.wready = 1'b1;
        #1;
        chk("areset_write", {31'd0, bus.write}, 32'd0);
        chk("areset_out", {21'd0, bus.out}, 32'd0);
        chk("areset_busy", {31'd0, bus.busy}, 32'd0);
        chk("areset_wready", {28'd0, bus.req_wready}, 32'd0);
        tick();
        bus.req_data[1] = 11'sd11;
        bus.req_data[3] = 11'sd33;
        bus.req_write = 4'b1010;
        push(1, 11'd11);
        rst = 1'b0;
        tick();
        chk("areset_first_grant", {30'd0, bus.grant_id}, 32'd1);
        tick();
        bus.req_write = '0;
        bus.wready = 1'b0;
        tick();
        tick();

`ifdef PORT_ARB_COUNT_EN
        do_reset();
        chk("cnt_xfer_rst", {16'd0, xfer_count}, 32'd0);
        chk("cnt_abort_rst", {24'd0, abort_count}, 32'd0);
        bus.req_data[0] = 11'sd9;
        for (int k = 0; k < 10; k++) push(0, 11'd9);
        bus.req_write = 4'b0001;
        bus.wready = 1'b1;
        for (int k = 0; k < 29; k++) tick();
        bus.req_write = '0;
        bus.wready = 1'b0;
        tick();
        tick();
        chk("cnt_xfer", {16'd0, xfer_count}, 32'd10);
        for (int k = 0; k < 300; k++) begin
            bus.req_write = 4'b0001;
            tick();
            bus.req_write = '0;
            tick();
        end
        chk("cnt_abort_sat", {24'd0, abort_count}, 32'd255);
        chk("cnt_xfer_hold", {16'd0, xfer_count}, 32'd10);
`endif

        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
